// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: one nibble per clock with a 4-bit borrow-lookahead and registered
// inter-nibble borrow. Define SUB_SIGNED_OVF_EN to add the registered signed-overflow output ovf_o.
module nibble_serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [KW-1:0]    k_q, k_d;
  logic             bw_q, bw_d;

  logic [3:0]       an, bn, g, p, nd;
  logic [4:0]       bw;
  logic [WIDTH-1:0] diff_new;
  logic             last_nib;

  // Borrow lookahead for the current nibble, all borrows expanded from bw_q.
  always_comb begin
    an    = a_q[4*k_q +: 4];
    bn    = b_q[4*k_q +: 4];
    g     = ~an & bn;
    p     = ~(an ^ bn);
    bw[0] = bw_q;
    bw[1] = g[0] | (p[0] & bw_q);
    bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bw_q);
    bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bw_q);
    bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
            (p[3] & p[2] & p[1] & p[0] & bw_q);
    nd    = an ^ bn ^ bw[3:0];
    diff_new = diff_q;
    diff_new[4*k_q +: 4] = nd;
    last_nib = (k_q == KW'(NIB - 1));
  end

`ifdef SUB_SIGNED_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    k_d     = k_q;
    bw_d    = bw_q;
`ifdef SUB_SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          k_d     = '0;
          bw_d    = 1'b0;
`ifdef SUB_SIGNED_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = StBusy;
        end
      end
      StBusy: begin
        diff_d = diff_new;
        bw_d   = bw[4];
        k_d    = k_q + KW'(1);
        if (last_nib) begin
          state_d = StDone;
`ifdef SUB_SIGNED_OVF_EN
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_new[WIDTH-1] ^ a_q[WIDTH-1]);
`endif
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      k_q     <= '0;
      bw_q    <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      k_q     <= k_d;
      bw_q    <= bw_d;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign diff_o      = diff_q;
  assign borrow_o    = bw_q;
`ifdef SUB_SIGNED_OVF_EN
  assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed, table-driven bench for nibble_serial_subtractor (WIDTH 16).
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, borrow;
  logic [15:0] a, b, diff;
`ifdef SUB_SIGNED_OVF_EN
  logic        ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .diff_o      (diff),
    .borrow_o    (borrow)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf_o       (ovf)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];
  vec_t tp[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one operand pair and wait for out_valid; checks the 4-cycle latency.
  task automatic start_and_wait(input logic [15:0] av, input logic [15:0] bv);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, 32'd4);
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_xfer_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_xfer_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    start_and_wait(v.a, v.b);
    chk("diff", {16'b0, diff}, {16'b0, v.diff});
    chk("borrow", {31'b0, borrow}, {31'b0, v.borrow});
`ifdef SUB_SIGNED_OVF_EN
    chk("ovf", {31'b0, ovf}, {31'b0, v.ovf});
`endif
    finish_op();
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hABCD, 16'h0000, 16'hABCD, 1'b0, 1'b0};
    vecs[6] = '{16'h0005, 16'h0009, 16'hFFFC, 1'b1, 1'b0};
    vecs[7] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b1};
    vecs[9] = '{16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b0};
    tp[0]   = '{16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0};
    tp[1]   = '{16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0};
    tp[2]   = '{16'h4321, 16'h1111, 16'h3210, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_diff", {16'b0, diff}, 32'd0);
    chk("rst_borrow", {31'b0, borrow}, 32'd0);
`ifdef SUB_SIGNED_OVF_EN
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Back-pressure: result held 3 cycles, in_valid pulse ignored.
    start_and_wait(16'h5678, 16'h1234);
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_diff", {16'b0, diff}, 32'h4444);
      chk("bp_borrow", {31'b0, borrow}, 32'd0);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    finish_op();
    @(posedge clk); #1;
    chk("bp_no_queue", {31'b0, out_valid}, 32'd0);

    // Reset in the second BUSY cycle aborts the operation.
    a = 16'h1234; b = 16'h0234; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_diff", {16'b0, diff}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec('{16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0});

    // Throughput: three ops back to back with out_ready high.
    begin
      int  issued, got, last_c;
      bit  prev_rdy;
      issued = 0; got = 0; last_c = 0;
      a = tp[0].a; b = tp[0].b; in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 60 && got < 3; c++) begin
        prev_rdy = in_ready;
        @(posedge clk); #1;
        if (prev_rdy && in_valid) begin
          issued++;
          if (issued < 3) begin
            a = tp[issued].a; b = tp[issued].b;
          end else begin
            in_valid = 1'b0;
          end
        end
        if (out_valid) begin
          chk("tp_diff", {16'b0, diff}, {16'b0, tp[got].diff});
          chk("tp_borrow", {31'b0, borrow}, {31'b0, tp[got].borrow});
          if (got > 0) chk("tp_interval", c - last_c, 32'd6);
          last_c = c;
          got++;
        end
      end
      chk("tp_count", got, 32'd3);
      in_valid = 1'b0; out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle 16-bit unsigned/two's-complement subtractor for the ToyALU datapath, the subtract-direction counterpart of the single-cycle carry-lookahead adder. Processes one 4-bit nibble per clock with a borrow-lookahead chain and carries the borrow between nibbles in a register. Sits behind a valid/ready handshake on both sides, so the ALU sequencer can issue operands and collect results with back-pressure.

## Interface
- `WIDTH`, default 16: operand width. Must be a multiple of 4; `NIB = WIDTH/4` is the nibble count.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operands `a` and `b` are valid.
- `in_ready`  out  1: the block accepts operands; high only in IDLE.
- `a`  in  WIDTH: minuend.
- `b`  in  WIDTH: subtrahend.
- `out_valid`  out  1: `diff`, `borrow` and `ovf` are valid.
- `out_ready`  in  1: the consumer accepts the result.
- `diff`  out  WIDTH: `a - b` mod 2^WIDTH.
- `borrow`  out  1: unsigned underflow, i.e. `a < b`.
- `ovf`  out  1: signed overflow. Present only when `SUB_SIGNED_OVF_EN` is defined.

## Operation
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid & in_ready`, latch `a` and `b`, clear the nibble counter `k` and the borrow register, then go to BUSY.
- BUSY, one nibble per cycle, with bits `i = 4k..4k+3`:
  - Generate: `g_i = ~a_i & b_i`.
  - Propagate: `p_i = ~(a_i ^ b_i)`.
  - Borrow lookahead: `bw_{i+1} = g_i | (p_i & bw_i)`. All four in-nibble borrows are computed in lookahead form from `bw_{4k}`, not rippled.
  - Difference: `diff_i = a_i ^ b_i ^ bw_i`.
  - Write nibble `k` of the `diff` register, store `bw_{4k+4}`, then `k <= k+1`.
  - When `k == NIB-1`, go to DONE.
- DONE:
  - `out_valid = 1`, and `borrow` equals the final nibble borrow.
  - Outputs are held stable until `out_ready`; then go to IDLE.
- In BUSY and DONE, `in_ready = 0`. Any `in_valid` is ignored; operands are not queued.
- Arithmetic:
  - `diff` is exact modulo 2^WIDTH.
  - `borrow = 1` iff `a < b` unsigned.
  - `a == b` gives `diff = 0`, `borrow = 0`.
  - Subtracting 0 passes `a` through unchanged.
- `diff` is written nibble by nibble during BUSY. Its value is defined only while `out_valid = 1`.

## Timing
- Reset values while `rst = 1` (asynchronous):
  - State IDLE, `in_ready = 1`.
  - `out_valid = 0`, `diff = 0`, `borrow = 0`, `ovf = 0`.
  - Counter and borrow register = 0.
- Latency: operands accepted at edge N give `out_valid = 1` after edge N+NIB. For WIDTH 16 that is 4 cycles.
- Result handshake: the transfer completes on the edge where `out_valid & out_ready`. The block is in IDLE after that edge, and `in_ready = 1` in the following cycle.
- Back-to-back issue: with `out_ready` tied high, one operation completes every NIB+2 cycles (6 for WIDTH 16).
- Reset mid-operation, in BUSY or DONE: the operation is aborted, no result is emitted, and all outputs take their reset values immediately.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- `SUB_SIGNED_OVF_EN` defined:
  - Port `ovf` exists.
  - It is registered on entry to DONE as `(a[W-1] ^ b[W-1]) & (diff[W-1] ^ a[W-1])`, using the latched operands.
  - It is held through DONE and reset to 0.
- `SUB_SIGNED_OVF_EN` undefined:
  - No `ovf` port and no associated logic.
  - All other behaviour is identical.

## Test plan
- Basic subtract: accept `0x1234 - 0x0234` -> `diff = 0x1000`, `borrow = 0`. `out_valid` rises exactly 4 cycles after the accept edge.
- Full borrow chain: `0x0000 - 0x0001` -> `diff = 0xFFFF`, `borrow = 1`, with the borrow propagated through all 4 nibbles. Also `0xFFFF - 0xFFFF` -> `diff = 0x0000`, `borrow = 0`.
- Signed overflow:
  - `0x8000 - 0x0001` -> `diff = 0x7FFF`, `borrow = 0`, `ovf = 1` with the macro defined.
  - `0x7FFF - 0xFFFF` -> `diff = 0x8000`, `borrow = 1`, `ovf = 1`.
  - Build without the macro: the `ovf` port is absent and `diff`/`borrow` are unchanged.
- Back-pressure: hold `out_ready = 0` for 3 cycles in DONE -> `diff`, `borrow` and `out_valid` stay stable and `in_ready = 0`. An `in_valid` pulse with `0xAAAA`/`0x5555` during this time is ignored.
- Reset mid-op: assert `rst` in the second BUSY cycle -> `out_valid = 0`, `diff = 0`, `in_ready = 1` immediately. After release, `0x0100 - 0x0001` -> `0x00FF`, `borrow = 0`.
- Throughput: with `in_valid` and `out_ready` held high, issue 3 operations back to back -> results appear every 6 cycles in issue order, each with the correct difference.
